// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and funct3 legality helper for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  localparam int unsigned RSP_TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  // Stores only know signless sizes; loads add the unsigned byte/half variants.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    logic ok;
    if (is_store) begin
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end else begin
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory request/response bundle between the load/store unit (master) and memory (slave).
interface lsu_if;
  logic        dm_req_valid;
  logic        dm_req_ready;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_rsp_valid;
  logic [31:0] dm_rsp_data;

  modport master (
    output dm_req_valid, dm_we, dm_addr, dm_be, dm_wdata,
    input  dm_req_ready, dm_rsp_valid, dm_rsp_data
  );

  modport slave (
    input  dm_req_valid, dm_we, dm_addr, dm_be, dm_wdata,
    output dm_req_ready, dm_rsp_valid, dm_rsp_data
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store byte enables / replicated data and load extraction.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rsp_word,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data
);

  logic [31:0] w_shifted;

  // Size-dependent lane selection; funct3[2] selects zero extension.
  always_comb begin
    o_be        = 4'b0000;
    o_wdata     = 32'h0000_0000;
    o_load_data = 32'h0000_0000;
    w_shifted   = i_rsp_word >> {i_off, 3'b000};
    case (i_funct3[1:0])
      2'b00: begin
        o_be    = BE_BYTE << i_off;
        o_wdata = {4{i_store_data[7:0]}};
        if (i_funct3[2]) begin
          o_load_data = {24'h00_0000, w_shifted[7:0]};
        end else begin
          o_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
        end
      end
      2'b01: begin
        o_be    = BE_HALF << i_off;
        o_wdata = {2{i_store_data[15:0]}};
        if (i_funct3[2]) begin
          o_load_data = {16'h0000, w_shifted[15:0]};
        end else begin
          o_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
        end
      end
      2'b10: begin
        o_be        = BE_WORD;
        o_wdata     = i_store_data;
        o_load_data = w_shifted;
      end
      default: begin
        o_be        = 4'b0000;
        o_wdata     = 32'h0000_0000;
        o_load_data = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage data-memory initiator with alignment, extension and response timeout.
// Define LSU_MISALIGN_TRAP_EN to turn misaligned half/word accesses into error completions.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned RSP_TIMEOUT = RSP_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        Mem_Read_in,
  input  logic        Mem_Write_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] ALU_Results_in,
  input  logic [31:0] Write_Data_in,
  output logic        stall_out,
  output logic        done_out,
  output logic        err_out,
  output logic [31:0] Read_data,
  lsu_if.master       dm
);

  localparam logic [7:0] TIMEOUT_C = 8'(RSP_TIMEOUT);

  lsu_state_e  r_state;
  lsu_state_e  w_next;
  logic [7:0]  r_cnt;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;
  logic        r_we;
  logic        r_done;
  logic        r_err;
  logic [31:0] r_read_data;
  logic        r_dm_req_valid;
  logic        r_dm_we;
  logic [31:0] r_dm_addr;
  logic [3:0]  r_dm_be;
  logic [31:0] r_dm_wdata;

  logic        w_access;
  logic        w_trap;
  logic        w_err;
  logic        w_dir_we;
  logic [7:0]  w_cnt_next;
  logic        w_timeout;
  logic [2:0]  w_src_f3;
  logic [1:0]  w_src_lo;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;

  assign w_access   = req_valid & (Mem_Read_in | Mem_Write_in);
  assign w_cnt_next = r_cnt + 8'd1;
  assign w_timeout  = (w_cnt_next == TIMEOUT_C);
  assign w_src_f3   = (r_state == ST_IDLE) ? funct3_in : r_funct3;
  assign w_src_lo   = (r_state == ST_IDLE) ? ALU_Results_in[1:0] : r_addr_lo;
  assign w_dir_we   = (r_state == ST_IDLE) ? Mem_Write_in : r_we;
  assign stall_out  = (r_state == ST_REQ) || (r_state == ST_WAIT) ||
                      ((r_state == ST_IDLE) && w_access);

  // Misalignment detection on the incoming request; only fatal when the trap is built in.
  always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
    w_trap = ((funct3_in[1:0] == 2'b01) && ALU_Results_in[0]) ||
             ((funct3_in[1:0] == 2'b10) && (ALU_Results_in[1:0] != 2'b00));
`else
    w_trap = 1'b0;
`endif
  end

  // Low address bits are forced down to the access size; trapped accesses never reach memory.
  always_comb begin
    case (w_src_f3[1:0])
      2'b00:   w_off = w_src_lo;
      2'b01:   w_off = {w_src_lo[1], 1'b0};
      default: w_off = 2'b00;
    endcase
  end

  lsu_lane_align u_align (
    .i_funct3     (w_src_f3),
    .i_off        (w_off),
    .i_store_data (Write_Data_in),
    .i_rsp_word   (dm.dm_rsp_data),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load_data)
  );

  // Next-state logic; a handshake in the same cycle as the timeout wins.
  always_comb begin
    w_next = r_state;
    w_err  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_access) begin
          if (!f3_legal(funct3_in, Mem_Write_in) || w_trap) begin
            w_next = ST_DONE;
            w_err  = 1'b1;
          end else begin
            w_next = ST_REQ;
          end
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (dm.dm_req_ready) begin
          w_next = r_we ? ST_DONE : ST_WAIT;
        end else if (w_timeout) begin
          w_next = ST_DONE;
          w_err  = 1'b1;
        end else begin
          w_next = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (dm.dm_rsp_valid) begin
          w_next = ST_DONE;
        end else if (w_timeout) begin
          w_next = ST_DONE;
          w_err  = 1'b1;
        end else begin
          w_next = ST_WAIT;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // State, timeout counter, latched request and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_cnt          <= 8'd0;
      r_funct3       <= 3'b000;
      r_addr_lo      <= 2'b00;
      r_we           <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_read_data    <= 32'h0000_0000;
      r_dm_req_valid <= 1'b0;
      r_dm_we        <= 1'b0;
      r_dm_addr      <= 32'h0000_0000;
      r_dm_be        <= 4'b0000;
      r_dm_wdata     <= 32'h0000_0000;
    end else begin
      r_state <= w_next;
      r_done  <= (w_next == ST_DONE);
      r_err   <= (w_next == ST_DONE) && w_err;
      if ((w_next == ST_DONE) && !w_dir_we) begin
        r_read_data <= w_err ? 32'h0000_0000 : w_load_data;
      end else begin
        r_read_data <= r_read_data;
      end
      if ((r_state == ST_REQ) || (r_state == ST_WAIT)) begin
        r_cnt <= w_cnt_next;
      end else begin
        r_cnt <= 8'd0;
      end
      if ((r_state == ST_IDLE) && w_access) begin
        r_funct3  <= funct3_in;
        r_addr_lo <= ALU_Results_in[1:0];
        r_we      <= Mem_Write_in;
      end else begin
        r_funct3  <= r_funct3;
        r_addr_lo <= r_addr_lo;
        r_we      <= r_we;
      end
      if ((r_state == ST_IDLE) && (w_next == ST_REQ)) begin
        r_dm_req_valid <= 1'b1;
        r_dm_we        <= Mem_Write_in;
        r_dm_addr      <= {ALU_Results_in[31:2], 2'b00};
        r_dm_be        <= w_be;
        r_dm_wdata     <= w_wdata;
      end else if ((r_state == ST_REQ) && (w_next != ST_REQ)) begin
        r_dm_req_valid <= 1'b0;
      end else begin
        r_dm_req_valid <= r_dm_req_valid;
      end
    end
  end

  assign done_out        = r_done;
  assign err_out         = r_err;
  assign Read_data       = r_read_data;
  assign dm.dm_req_valid = r_dm_req_valid;
  assign dm.dm_we        = r_dm_we;
  assign dm.dm_addr      = r_dm_addr;
  assign dm.dm_be        = r_dm_be;
  assign dm.dm_wdata     = r_dm_wdata;

endmodule
